// File: rtl/at_cmd_sequencer.sv
// AT command sequencer: sends CIPMUX then CIPSERVER to a uart_tx and waits for "OK" after each.
// `define AT_RESP_CHECK_EN to build the reply matcher with timeout/retry; otherwise a fixed settle delay is used.
module at_cmd_sequencer #(
  parameter int unsigned GAP_CYCLES   = 5000,
  parameter int unsigned RESP_TIMEOUT = 1000000,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] tx_data,
  output logic       tx_wrsig,
  input  logic       rx_int,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cmd_idx
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [103:0] CMD0 = {"AT+CIPMUX=1", 8'h0D, 8'h0A};
  localparam logic [167:0] CMD1 = {"AT+CIPSERVER=1,8080", 8'h0D, 8'h0A};

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, GAP, RESP, SETTLE, DONE, ERR} state_t;

  state_t          state;
  logic [4:0]      ptr;
  logic [4:0]      last_ptr;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   wait_cnt;

  function automatic logic [7:0] rom_byte(input logic idx, input logic [4:0] p);
    if (idx) rom_byte = CMD1[8*(20 - int'(p)) +: 8];
    else     rom_byte = CMD0[8*(12 - int'(p)) +: 8];
  endfunction

  assign last_ptr = cmd_idx ? 5'd20 : 5'd12;

`ifdef AT_RESP_CHECK_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry;
  logic          rx_int_q;
  logic          o_seen;
  logic          rx_fall;
  logic          ok_match;

  assign rx_fall  = rx_int_q & ~rx_int;
  assign ok_match = rx_fall & o_seen & (rx_data == 8'h4B);
`else
  logic unused_cfg;
  assign unused_cfg = ^{rx_int, rx_data, MAX_RETRY};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_wrsig <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cmd_idx  <= 1'b0;
      ptr      <= '0;
      gap_cnt  <= '0;
      wait_cnt <= '0;
`ifdef AT_RESP_CHECK_EN
      retry    <= '0;
      rx_int_q <= 1'b0;
      o_seen   <= 1'b0;
`endif
    end else begin
      tx_wrsig <= 1'b0;
      done     <= 1'b0;
`ifdef AT_RESP_CHECK_EN
      rx_int_q <= rx_int;
`endif
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state   <= LOAD;
              busy    <= 1'b1;
              cmd_idx <= 1'b0;
              ptr     <= '0;
              error   <= 1'b0;
`ifdef AT_RESP_CHECK_EN
              retry   <= '0;
`endif
            end
          end
          // Strobe is registered here so it coincides with the new tx_data in STROBE.
          LOAD: begin
            tx_data  <= rom_byte(cmd_idx, ptr);
            tx_wrsig <= 1'b1;
            state    <= STROBE;
          end
          STROBE: begin
            gap_cnt <= '0;
            state   <= GAP;
          end
          // STROBE and LOAD each take one cycle, so GAP lasts GAP_CYCLES-1 cycles.
          GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 2)) begin
              gap_cnt  <= '0;
              wait_cnt <= '0;
              if (ptr == last_ptr) begin
                ptr <= '0;
`ifdef AT_RESP_CHECK_EN
                o_seen <= 1'b0;
                state  <= RESP;
`else
                state  <= SETTLE;
`endif
              end else begin
                ptr   <= ptr + 5'd1;
                state <= LOAD;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
`ifdef AT_RESP_CHECK_EN
          RESP: begin
            if (rx_fall) o_seen <= (rx_data == 8'h4F);
            if (ok_match) begin
              if (!cmd_idx) begin
                cmd_idx <= 1'b1;
                retry   <= '0;
                state   <= LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end
            end else if (wait_cnt == TW'(RESP_TIMEOUT - 1)) begin
              if (retry < RW'(MAX_RETRY)) begin
                retry <= retry + RW'(1);
                ptr   <= '0;
                state <= LOAD;
              end else begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= ERR;
              end
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
          ERR: state <= IDLE;
`else
          SETTLE: begin
            if (wait_cnt == TW'(RESP_TIMEOUT - 1)) begin
              if (!cmd_idx) begin
                cmd_idx <= 1'b1;
                state   <= LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
`endif
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Directed bench for at_cmd_sequencer with GAP_CYCLES=4, RESP_TIMEOUT=64, MAX_RETRY=2.
// Covers both builds; reply-matching scenarios apply only when AT_RESP_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_at_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wrsig;
  logic       rx_int = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy;
  logic       done;
  logic       error;
  logic       cmd_idx;

  at_cmd_sequencer #(
    .GAP_CYCLES(4),
    .RESP_TIMEOUT(64),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .tx_data(tx_data),
    .tx_wrsig(tx_wrsig),
    .rx_int(rx_int),
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .error(error),
    .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_stamp = 0;
  logic [7:0] pdata[$];
  int         pstamp[$];
  logic       pidx[$];
  logic [7:0] expb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_wrsig) begin
      pdata.push_back(tx_data);
      pstamp.push_back(cyc);
      pidx.push_back(cmd_idx);
    end
    if (done) begin
      done_cnt   <= done_cnt + 1;
      done_stamp <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_int  = 1'b1;
    repeat (3) tick();
    rx_int = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && pdata.size() < n; i++) tick();
    chk("pulse_count", pdata.size(), n);
  endtask

  task automatic clear_log();
    pdata.delete();
    pstamp.delete();
    pidx.delete();
  endtask

  initial begin
    string s0;
    string s1;
    int t0;
    int done0;
    s0 = "AT+CIPMUX=1";
    s1 = "AT+CIPSERVER=1,8080";
    for (int i = 0; i < s0.len(); i++) expb.push_back(s0[i]);
    expb.push_back(8'h0D);
    expb.push_back(8'h0A);
    for (int i = 0; i < s1.len(); i++) expb.push_back(s1[i]);
    expb.push_back(8'h0D);
    expb.push_back(8'h0A);

    repeat (3) tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_wrsig", tx_wrsig, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cmd_idx", cmd_idx, 1'b0);
    rst_n = 1'b1;
    tick();

    // Full script; rx noise during transmit and a second start while busy must not disturb it.
    t0 = cyc;
    pulse_start();
    chk("busy_on", busy, 1'b1);
    send_rx(8'h4B);
    send_rx(8'h4F);
    pulse_start();
    wait_pulses(13, 200);
`ifdef AT_RESP_CHECK_EN
    repeat (4) tick();
    send_rx(8'h4B);
    repeat (3) tick();
    chk("no_prearm_idx", cmd_idx, 1'b0);
    chk("no_prearm_pulses", pdata.size(), 13);
    send_rx(8'h78);
    send_rx(8'h4F);
    send_rx(8'h4B);
    wait_pulses(34, 400);
    repeat (4) tick();
    send_rx(8'h4F);
    send_rx(8'h4B);
`else
    wait_pulses(34, 400);
`endif
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    chk("done_cnt", done_cnt, 1);
    chk("busy_after_done", busy, 1'b0);
    chk("error_after_done", error, 1'b0);
    if (pdata.size() == 34) begin
      chk("first_latency", pstamp[0] - t0, 2);
      chk("first_byte", pdata[0], 8'h41);
      chk("second_byte", pdata[1], 8'h54);
      chk("second_spacing", pstamp[1] - pstamp[0], 5);
      chk("cmd0_last", pdata[12], 8'h0A);
      chk("cmd1_last", pdata[33], 8'h0A);
      chk("idx_cmd0", pidx[0], 1'b0);
      chk("idx_cmd1", pidx[13], 1'b1);
      for (int i = 0; i < 34; i++) chk($sformatf("byte%0d", i), pdata[i], expb[i]);
      for (int i = 1; i < 34; i++)
        if (i != 13) chk($sformatf("spacing%0d", i), pstamp[i] - pstamp[i-1], 5);
`ifndef AT_RESP_CHECK_EN
      chk("settle_pause", pstamp[13] - pstamp[12], 69);
      chk("done_latency", done_stamp - pstamp[33], 68);
`endif
    end

    // Abort in the GAP after the fifth byte.
    clear_log();
    pulse_start();
    wait_pulses(5, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_wrsig", tx_wrsig, 1'b0);
    chk("abort_tx_data", tx_data, 8'h49);
    repeat (30) tick();
    chk("abort_no_tx", pdata.size(), 5);

    // Reset while waiting after cmd0.
    clear_log();
    pulse_start();
    wait_pulses(13, 200);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_wrsig", tx_wrsig, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_error", error, 1'b0);
    chk("mid_rst_cmd_idx", cmd_idx, 1'b0);
    rst_n = 1'b1;
    tick();

    // Start and abort together in IDLE: abort wins.
    clear_log();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    repeat (10) tick();
    chk("start_abort_no_tx", pdata.size(), 0);

`ifdef AT_RESP_CHECK_EN
    // No reply: cmd0 sent three times, then error.
    clear_log();
    done0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 1000 && !error; i++) tick();
    tick();
    chk("err_level", error, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk("err_pulses", pdata.size(), 39);
    chk("err_no_done", done_cnt, done0);
    repeat (5) tick();
    chk("err_held", error, 1'b1);

    // Next start clears error; "O","x","K" must not match and a retry follows.
    clear_log();
    pulse_start();
    chk("err_cleared", error, 1'b0);
    wait_pulses(13, 200);
    repeat (4) tick();
    send_rx(8'h4F);
    send_rx(8'h78);
    send_rx(8'h4B);
    chk("oxk_idx", cmd_idx, 1'b0);
    wait_pulses(26, 200);
    chk("oxk_retry_idx", cmd_idx, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("oxk_abort_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/at_cmd_sequencer.md
AT_CMD_SEQUENCER -- requirements
Module: at_cmd_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 5000: clk cycles from one tx_wrsig pulse to the next byte load (≥ one UART frame).
REQ-002 Parameter RESP_TIMEOUT, default 1000000: clk cycles allowed for the "OK" reply per command.
REQ-003 Parameter MAX_RETRY, default 2: resends of a command after a timeout before error.
REQ-004 clk  input  1  baud-domain clock (50 MHz/baud/16 tick clock); the single clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to run the full command script.
REQ-007 abort  input  1  one-cycle request to stop the script immediately.
REQ-008 tx_data  output  8  byte presented to uart_tx datain.
REQ-009 tx_wrsig  output  1  one-cycle write strobe to uart_tx wrsig.
REQ-010 rx_int  input  1  uart_rx busy flag; high while a byte is being received.
REQ-011 rx_data  input  8  uart_rx dataout; valid when rx_int falls.
REQ-012 busy  output  1  high from start acceptance until DONE, ERR or abort.
REQ-013 done  output  1  one-cycle pulse when the script completes.
REQ-014 error  output  1  level; high after retries are exhausted, until next accepted start or reset.
REQ-015 cmd_idx  output  1  index of the command in progress (0 = CIPMUX, 1 = CIPSERVER).

Function
REQ-016 Internal ROM SHALL hold cmd0 "AT+CIPMUX=1\r\n" (13 bytes) and cmd1 "AT+CIPSERVER=1,8080\r\n" (21 bytes).
REQ-017 FSM states SHALL be IDLE, LOAD, STROBE, GAP, RESP, SETTLE, DONE, ERR.
REQ-018 IDLE: start=1 -> LOAD next cycle; busy=1, cmd_idx=0, byte pointer=0, retry count=0, error cleared.
REQ-019 LOAD: tx_data <= ROM[cmd_idx][ptr]; -> STROBE; tx_data SHALL stay stable until the next LOAD.
REQ-020 STROBE: tx_wrsig=1 for exactly one cycle, gap counter cleared; -> GAP.
REQ-021 GAP: counts GAP_CYCLES cycles including the STROBE cycle; then ptr+1 and LOAD if bytes remain, else ptr=0 and RESP (or SETTLE, see REQ-031).
REQ-022 Byte spacing SHALL therefore be exactly GAP_CYCLES+1 cycles between consecutive tx_wrsig pulses.
REQ-023 RESP: a received byte SHALL be taken on each rx_int high-to-low edge (rx_int registered once); "OK" SHALL match when byte 'K' (0x4B) directly follows byte 'O' (0x4F); other bytes reset the match.
REQ-024 RESP, match: cmd_idx=0 -> cmd_idx=1, retry=0, LOAD; cmd_idx=1 -> DONE.
REQ-025 RESP, timeout counter reaching RESP_TIMEOUT: retry<MAX_RETRY -> retry+1, ptr=0, LOAD (same command); else ERR.
REQ-026 Match and timeout in the same cycle: match SHALL win.
REQ-027 DONE: done=1 one cycle, busy=0, -> IDLE. ERR: error=1, busy=0, -> IDLE with error held.
REQ-028 start while busy=1 SHALL be ignored; start and abort together in IDLE: abort wins, start ignored.
REQ-029 abort in any non-IDLE state: next cycle IDLE, busy=0, tx_wrsig=0, done=0, error unchanged; tx_data holds last value.
REQ-030 Received bytes outside RESP SHALL be discarded and SHALL not pre-arm the "OK" match.

Reset
REQ-031 rst_n=0 at a clk edge SHALL force IDLE; tx_data=0x00, tx_wrsig=0, busy=0, done=0, error=0, cmd_idx=0, all counters and match flag 0, including mid-byte or mid-RESP.

Configuration
REQ-032 Macro AT_RESP_CHECK_EN: defined -> RESP behaves per REQ-023..REQ-026; undefined -> RESP logic, timeout counter and retry counter are not built, GAP end of last byte goes to SETTLE, which waits RESP_TIMEOUT cycles then advances as on a match; error SHALL stay 0 and rx_int/rx_data are unused.

Verification (GAP_CYCLES=4, RESP_TIMEOUT=64, MAX_RETRY=2)
REQ-033 start pulse -> tx_wrsig first pulse 2 cycles later with tx_data=0x41, then 0x54 five cycles later; 13 pulses for cmd0, last byte 0x0A.
REQ-034 Macro on, inject "xOK" after cmd0 -> cmd_idx=1, cmd1 sent (21 pulses, 0x41..0x0A); inject "OK" -> done pulse, busy=0.
REQ-035 Macro on, no reply -> cmd0 sent 3 times total, then error=1, busy=0, done never asserted; next start clears error.
REQ-036 Inject "O","x","K" in RESP -> no match; timeout retry occurs.
REQ-037 abort during 5th byte GAP -> next cycle busy=0, no further tx_wrsig; rst_n=0 mid-RESP -> all outputs at reset values next edge.
REQ-038 Macro off -> both commands sent with RESP_TIMEOUT-cycle pause between them, done pulse, error=0 regardless of rx activity.
